mem_stage_wb: RTL and testbench

Memory-access stage plus MEM/WB pipeline register. Consumes the EX/MEM register outputs (ALU result, store data, control bits, instruction), performs the data-memory access over a ready/request handshake with wait states, stalls the upstream pipeline while the access is outstanding, and registers the write-back value, destination and enable for the WB stage. Also keeps a sticky memory-timeout flag and a saturating stall counter.

---
 rtl/mem_stage_wb.sv | 136 +++++++++++++
 tb/tb_mem_stage_wb.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_wb.sv
// Memory-access stage and MEM/WB pipeline register: runs one data-memory access at a time
// over a req/ready handshake, stalls upstream while it is outstanding, aborts on timeout.
module mem_stage_wb #(
    parameter int WORD_LEN        = 32,
    parameter int INSTRUCTION_LEN = 32,
    parameter int REG_ADDR_LEN    = 3,
    parameter int TIMEOUT         = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WORD_LEN-1:0]        PR3_alu_out,
    input  logic [WORD_LEN-1:0]        PR3_store_data,
    input  logic [INSTRUCTION_LEN-1:0] PR3_instruction,
    input  logic [REG_ADDR_LEN-1:0]    PR3_dest,
    input  logic                       PR3_MEM_read,
    input  logic                       PR3_MEM_write,
    input  logic                       PR3_sel_RF_write_src_ALU,
    input  logic                       PR3_sel_RF_write_src_MEM,
    input  logic                       PR3_RF_write_en,
    output logic                       dm_req,
    output logic                       dm_we,
    output logic [WORD_LEN-1:0]        dm_addr,
    output logic [WORD_LEN-1:0]        dm_wdata,
    input  logic [WORD_LEN-1:0]        dm_rdata,
    input  logic                       dm_ready,
    output logic                       mem_stall,
    output logic [WORD_LEN-1:0]        PR4_wb_data,
    output logic [REG_ADDR_LEN-1:0]    PR4_dest,
    output logic                       PR4_RF_write_en,
    output logic [INSTRUCTION_LEN-1:0] PR4_instruction,
    output logic                       mem_error,
    output logic [15:0]                stall_count
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t                     state;
    logic [7:0]                 wait_cnt;
    logic [INSTRUCTION_LEN-1:0] cap_instruction;
    logic [REG_ADDR_LEN-1:0]    cap_dest;
    logic                       cap_sel_mem;
    logic                       cap_rf_we;
    logic                       mem_op;
    logic                       timeout_hit;

    // The ALU-source select is implied by sel_MEM being low; kept only for port completeness.
    logic unused_sel_alu;
    assign unused_sel_alu = PR3_sel_RF_write_src_ALU;

    assign mem_op      = PR3_MEM_read | PR3_MEM_write;
    assign timeout_hit = (state == BUSY) && !dm_ready && (wait_cnt == TIMEOUT_LAST);
    assign mem_stall   = ((state == IDLE) && mem_op) ||
                         ((state == BUSY) && !dm_ready && !timeout_hit);
    assign dm_req      = (state == BUSY);

    // NOTE: every register here is non-blocking (<=) so all state updates see pre-edge values;
    // the capture registers are reset too because dm_addr/dm_wdata must read 0 out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            wait_cnt        <= '0;
            dm_we           <= 1'b0;
            dm_addr         <= '0;
            dm_wdata        <= '0;
            cap_instruction <= '0;
            cap_dest        <= '0;
            cap_sel_mem     <= 1'b0;
            cap_rf_we       <= 1'b0;
            PR4_wb_data     <= '0;
            PR4_dest        <= '0;
            PR4_RF_write_en <= 1'b0;
            PR4_instruction <= '0;
            mem_error       <= 1'b0;
            stall_count     <= '0;
        end else begin
            if (mem_stall && (stall_count != 16'hFFFF))
                stall_count <= stall_count + 16'd1;

            case (state)
                IDLE: begin
                    if (mem_op) begin
                        dm_addr         <= PR3_alu_out;
                        dm_wdata        <= PR3_store_data;
                        dm_we           <= PR3_MEM_write;
                        cap_instruction <= PR3_instruction;
                        cap_dest        <= PR3_dest;
                        cap_sel_mem     <= PR3_sel_RF_write_src_MEM;
                        cap_rf_we       <= PR3_RF_write_en;
                        wait_cnt        <= '0;
                        state           <= BUSY;
                        PR4_wb_data     <= '0;
                        PR4_dest        <= '0;
                        PR4_RF_write_en <= 1'b0;
                        PR4_instruction <= '0;
                    end else begin
                        PR4_wb_data     <= PR3_alu_out;
                        PR4_dest        <= PR3_dest;
                        PR4_RF_write_en <= PR3_RF_write_en;
                        PR4_instruction <= PR3_instruction;
                    end
                end
                BUSY: begin
                    if (dm_ready) begin
                        PR4_wb_data     <= cap_sel_mem ? dm_rdata : dm_addr;
                        PR4_dest        <= cap_dest;
                        PR4_RF_write_en <= cap_rf_we;
                        PR4_instruction <= cap_instruction;
                        dm_we           <= 1'b0;
                        wait_cnt        <= '0;
                        state           <= IDLE;
                    end else if (timeout_hit) begin
                        // Abort: retire the instruction without a register write.
                        PR4_wb_data     <= dm_addr;
                        PR4_dest        <= cap_dest;
                        PR4_RF_write_en <= 1'b0;
                        PR4_instruction <= cap_instruction;
                        mem_error       <= 1'b1;
                        dm_we           <= 1'b0;
                        wait_cnt        <= '0;
                        state           <= IDLE;
                    end else begin
                        wait_cnt        <= wait_cnt + 8'd1;
                        PR4_wb_data     <= '0;
                        PR4_dest        <= '0;
                        PR4_RF_write_en <= 1'b0;
                        PR4_instruction <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_wb.sv
// Scoreboard bench for mem_stage_wb: stimulus pushes expected write-backs, a negedge
// monitor pops and compares whenever a non-bubble instruction appears in PR4.
module tb_mem_stage_wb;

    localparam int TIMEOUT = 15;

    typedef struct {
        logic [31:0] wb_data;
        logic [2:0]  dest;
        logic        we;
        logic [31:0] instr;
        bit          chk_data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PR3_alu_out, PR3_store_data, PR3_instruction;
    logic [2:0]  PR3_dest;
    logic        PR3_MEM_read, PR3_MEM_write;
    logic        PR3_sel_RF_write_src_ALU, PR3_sel_RF_write_src_MEM, PR3_RF_write_en;
    logic        dm_req, dm_we, dm_ready, mem_stall, PR4_RF_write_en, mem_error;
    logic [31:0] dm_addr, dm_wdata, dm_rdata, PR4_wb_data, PR4_instruction;
    logic [2:0]  PR4_dest;
    logic [15:0] stall_count;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_stalls = 0;
    logic exp_err = 1'b0;

    mem_stage_wb #(
        .WORD_LEN(32), .INSTRUCTION_LEN(32), .REG_ADDR_LEN(3), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .PR3_alu_out(PR3_alu_out), .PR3_store_data(PR3_store_data),
        .PR3_instruction(PR3_instruction), .PR3_dest(PR3_dest),
        .PR3_MEM_read(PR3_MEM_read), .PR3_MEM_write(PR3_MEM_write),
        .PR3_sel_RF_write_src_ALU(PR3_sel_RF_write_src_ALU),
        .PR3_sel_RF_write_src_MEM(PR3_sel_RF_write_src_MEM),
        .PR3_RF_write_en(PR3_RF_write_en),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready), .mem_stall(mem_stall),
        .PR4_wb_data(PR4_wb_data), .PR4_dest(PR4_dest), .PR4_RF_write_en(PR4_RF_write_en),
        .PR4_instruction(PR4_instruction), .mem_error(mem_error), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_nop();
        PR3_alu_out = '0; PR3_store_data = '0; PR3_instruction = '0; PR3_dest = '0;
        PR3_MEM_read = 1'b0; PR3_MEM_write = 1'b0;
        PR3_sel_RF_write_src_ALU = 1'b0; PR3_sel_RF_write_src_MEM = 1'b0;
        PR3_RF_write_en = 1'b0;
    endtask

    // Scoreboard monitor: a nonzero PR4 instruction marks a retired instruction.
    always @(negedge clk) begin
        if (rst && PR4_instruction != 0) begin
            if (sb.size() == 0) begin
                check("pr4_unexpected_instr", PR4_instruction, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pr4_instruction", PR4_instruction, e.instr);
                check("pr4_write_en", PR4_RF_write_en, e.we);
                if (e.chk_data) begin
                    check("pr4_wb_data", PR4_wb_data, e.wb_data);
                    check("pr4_dest", PR4_dest, e.dest);
                end
            end
        end
    end

    // Non-memory op; dm_ready is driven high with junk data to show it is ignored in IDLE.
    task automatic alu_op(input logic [31:0] alu, input logic [2:0] dest, input logic we,
                          input logic [31:0] instr);
        exp_t e;
        set_nop();
        PR3_alu_out = alu; PR3_dest = dest; PR3_RF_write_en = we; PR3_instruction = instr;
        PR3_sel_RF_write_src_ALU = 1'b1;
        dm_ready = 1'b1; dm_rdata = 32'hDEAD_BEEF;
        e.wb_data = alu; e.dest = dest; e.we = we; e.instr = instr; e.chk_data = 1'b1;
        sb.push_back(e);
        #1 check("alu_no_stall", mem_stall, 1'b0);
        @(posedge clk); #1;
        dm_ready = 1'b0;
        set_nop();
        check("alu_no_req", dm_req, 1'b0);
    endtask

    // Memory op answered after 'waits' BUSY cycles; waits < 0 means the memory never answers.
    task automatic mem_op(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] dest, input logic rf_we, input logic sel_mem,
                          input logic [31:0] instr, input int waits, input logic [31:0] rdata);
        exp_t e;
        int   last;
        int   stalls;
        int   reqs;
        last = (waits < 0) ? TIMEOUT - 1 : waits;
        set_nop();
        PR3_alu_out = addr; PR3_store_data = wdata; PR3_dest = dest; PR3_instruction = instr;
        PR3_MEM_read = ~wr; PR3_MEM_write = wr; PR3_RF_write_en = rf_we;
        PR3_sel_RF_write_src_MEM = sel_mem; PR3_sel_RF_write_src_ALU = ~sel_mem;
        e.wb_data = sel_mem ? rdata : addr; e.dest = dest; e.instr = instr;
        e.we = (waits < 0) ? 1'b0 : rf_we; e.chk_data = (waits >= 0);
        sb.push_back(e);
        stalls = 0; reqs = 0;
        #1;
        if (mem_stall) stalls++;
        check("idle_req_low", dm_req, 1'b0);
        for (int k = 0; k <= last; k++) begin
            @(posedge clk); #1;
            dm_ready = (k == waits);
            dm_rdata = (k == waits) ? rdata : (32'hBAD0_0000 | k);
            #1;
            if (dm_req) reqs++;
            if (mem_stall) stalls++;
            if (k == 0) begin
                check("dm_addr", dm_addr, addr);
                check("dm_we", dm_we, wr);
                if (wr) check("dm_wdata", dm_wdata, wdata);
            end
        end
        @(posedge clk); #1;
        dm_ready = 1'b0;
        set_nop();
        check("req_dropped", dm_req, 1'b0);
        check("req_cycles", reqs, last + 1);
        check("stall_cycles", stalls, (waits < 0) ? TIMEOUT : waits + 1);
        exp_stalls += (waits < 0) ? TIMEOUT : waits + 1;
        if (waits < 0) exp_err = 1'b1;
        check("stall_count", stall_count, exp_stalls);
        check("mem_error", mem_error, exp_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        dm_ready = 1'b0; dm_rdata = '0;
        set_nop();
        #2;
        check("rst_dm_req", dm_req, 1'b0);
        check("rst_dm_addr", dm_addr, 32'd0);
        check("rst_pr4_wb_data", PR4_wb_data, 32'd0);
        check("rst_pr4_instr", PR4_instruction, 32'd0);
        check("rst_mem_error", mem_error, 1'b0);
        check("rst_stall_count", stall_count, 16'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        alu_op(32'h2A, 3'd3, 1'b1, 32'h0000_0013);
        // Load 0x10, two wait states.
        mem_op(1'b0, 32'h10, 32'h0, 3'd5, 1'b1, 1'b1, 32'h0000_0103, 2, 32'h5C);
        // Store 0x77 to 0x04, zero wait.
        mem_op(1'b1, 32'h04, 32'h77, 3'd0, 1'b0, 1'b0, 32'h0000_0223, 0, 32'h0);
        // Ready arrives on the very cycle the timeout would fire: ready must win.
        mem_op(1'b0, 32'h20, 32'h0, 3'd6, 1'b1, 1'b1, 32'h0000_0303, TIMEOUT - 1, 32'h99);
        // Memory never answers: abort after TIMEOUT BUSY cycles.
        mem_op(1'b0, 32'h30, 32'h0, 3'd2, 1'b1, 1'b1, 32'h0000_0403, -1, 32'h0);
        alu_op(32'h55, 3'd1, 1'b1, 32'h0000_0513);
        check("mem_error_sticky", mem_error, 1'b1);
        // Back-to-back zero-wait loads.
        mem_op(1'b0, 32'h01, 32'h0, 3'd1, 1'b1, 1'b1, 32'h0000_0603, 0, 32'hA1);
        mem_op(1'b0, 32'h02, 32'h0, 3'd2, 1'b1, 1'b1, 32'h0000_0703, 0, 32'hA2);

        // Third load interrupted by reset during BUSY: no write-back may appear.
        set_nop();
        PR3_alu_out = 32'h03; PR3_MEM_read = 1'b1; PR3_RF_write_en = 1'b1;
        PR3_sel_RF_write_src_MEM = 1'b1; PR3_dest = 3'd4; PR3_instruction = 32'h0000_0803;
        @(posedge clk); #1;
        check("busy_req_high", dm_req, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("midrst_dm_req", dm_req, 1'b0);
        check("midrst_dm_addr", dm_addr, 32'd0);
        check("midrst_dm_we", dm_we, 1'b0);
        check("midrst_pr4_wb_data", PR4_wb_data, 32'd0);
        check("midrst_pr4_dest", PR4_dest, 3'd0);
        check("midrst_pr4_we", PR4_RF_write_en, 1'b0);
        check("midrst_pr4_instr", PR4_instruction, 32'd0);
        check("midrst_mem_error", mem_error, 1'b0);
        check("midrst_stall_count", stall_count, 16'd0);
        check("midrst_stall_comb", mem_stall, 1'b1);
        set_nop();
        exp_stalls = 0; exp_err = 1'b0;
        @(posedge clk); #1 rst = 1'b1;

        alu_op(32'h1234, 3'd7, 1'b1, 32'h0000_0913);
        repeat (3) @(posedge clk);
        #1 check("scoreboard_drained", sb.size(), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
